// File: rtl/vx_tcu_drl_acc_seq.sv
`default_nettype none
// ============================================================================
//  Module   : vx_tcu_drl_acc_seq
//  Function : Sequences a multi-step (K-chunk) dot-product accumulation
//             through an external combinational DRL accumulator. A request is
//             accepted, its step beats are streamed to the accumulator with
//             the proper lane mask and C-term, and the step sums are gathered
//             into a widened running sum. One result is returned per request.
//  Revision : 1.0  initial release
// ============================================================================
module vx_tcu_drl_acc_seq #(
    parameter int N         = 5,
    parameter int WI        = 26,
    parameter int WO        = 30,
    parameter int MAX_STEPS = 8,
    parameter int SW        = $clog2(MAX_STEPS + 1),
    parameter int WA        = WO + $clog2(MAX_STEPS),
    parameter int TW        = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  reset,
    // request
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [31:0]           req_id_i,
    input  logic [SW-1:0]         req_steps_i,
    input  logic [TW-1:0]         req_tail_i,
    input  logic [WI-1:0]         req_c_sig_i,
    input  logic                  req_c_sticky_i,
    // step beats
    input  logic                  step_valid_i,
    output logic                  step_ready_o,
    input  logic [(N-1)*WI-1:0]   step_sigs_i,
    input  logic [N-2:0]          step_sticky_i,
    // accumulator interface
    output logic                  acc_valid_o,
    output logic [31:0]           acc_req_id_o,
    output logic [N-2:0]          acc_lane_mask_o,
    output logic [N*WI-1:0]       acc_sigs_o,
    output logic [N-1:0]          acc_sticky_o,
    input  logic [WO-1:0]         acc_sig_i,
    input  logic                  acc_sticky_in_i,
    // result
    output logic                  res_valid_o,
    input  logic                  res_ready_i,
    output logic [31:0]           res_id_o,
    output logic [WA-1:0]         res_sig_o,
    output logic                  res_sticky_o
);

    localparam logic [SW-1:0] MAX_STEPS_C = SW'(MAX_STEPS);
    localparam logic [TW-1:0] VEC_LANES_C = TW'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [WA-1:0]   sum_q, sum_d;
    logic            sticky_q, sticky_d;
    logic [SW-1:0]   step_cnt_q, step_cnt_d;
    logic [SW-1:0]   steps_q, steps_d;
    logic [TW-1:0]   tail_q, tail_d;
    logic [WI-1:0]   c_sig_q, c_sig_d;
    logic            c_sticky_q, c_sticky_d;
    logic [31:0]     id_q, id_d;

    logic            w_in_run;
    logic            w_in_done;
    logic            w_req_fire;
    logic            w_step_fire;
    logic            w_last_step;
    logic            w_first_step;
    logic            w_tail_full;
    logic [SW-1:0]   w_steps_clamped;
    logic [N-2:0]    w_tail_mask;

    assign w_in_run        = (state_q == ST_RUN);
    assign w_in_done       = (state_q == ST_DONE);
    assign w_req_fire      = (state_q == ST_IDLE) && req_valid_i;
    assign w_step_fire     = w_in_run && step_valid_i;
    assign w_last_step     = ((step_cnt_q + SW'(1)) == steps_q);
    assign w_first_step    = (step_cnt_q == '0);
    assign w_tail_full     = (tail_q == '0) || (tail_q >= VEC_LANES_C);
    assign w_steps_clamped = (req_steps_i > MAX_STEPS_C) ? MAX_STEPS_C : req_steps_i;

    // Partial lane mask for the tail step: lane i active when i < tail.
    generate
        for (genvar gi = 0; gi < N - 1; gi++) begin : g_tail_mask
            assign w_tail_mask[gi] = w_tail_full || (TW'(gi) < tail_q);
        end
    endgenerate

    // Handshake flags follow the FSM state directly.
    assign req_ready_o  = (state_q == ST_IDLE);
    assign step_ready_o = w_in_run;
    assign acc_valid_o  = w_step_fire;
    assign acc_req_id_o = id_q;

    // Accumulator operands: vector lanes pass through, C-term only on the
    // first step; everything is forced to zero outside RUN to stay X-free.
    assign acc_lane_mask_o = !w_in_run   ? '0 :
                             w_last_step ? w_tail_mask : '1;
    assign acc_sigs_o      = !w_in_run ? '0 :
                             {(w_first_step ? c_sig_q : {WI{1'b0}}), step_sigs_i};
    assign acc_sticky_o    = !w_in_run ? '0 :
                             {(w_first_step & c_sticky_q), step_sticky_i};

    // Result is presented only while holding in DONE.
    assign res_valid_o  = w_in_done;
    assign res_id_o     = w_in_done ? id_q : '0;
    assign res_sig_o    = w_in_done ? sum_q : '0;
    assign res_sticky_o = w_in_done & sticky_q;

    // Next-state and datapath update; every register holds by default.
    always_comb begin
        state_d    = state_q;
        sum_d      = sum_q;
        sticky_d   = sticky_q;
        step_cnt_d = step_cnt_q;
        steps_d    = steps_q;
        tail_d     = tail_q;
        c_sig_d    = c_sig_q;
        c_sticky_d = c_sticky_q;
        id_d       = id_q;
        unique case (state_q)
            ST_IDLE: begin
                if (w_req_fire) begin
                    id_d       = req_id_i;
                    steps_d    = w_steps_clamped;
                    tail_d     = req_tail_i;
                    c_sig_d    = req_c_sig_i;
                    c_sticky_d = req_c_sticky_i;
                    step_cnt_d = '0;
                    if (w_steps_clamped == '0) begin
                        // No vector chunks: the result is just the C-term.
                        sum_d    = WA'($signed(req_c_sig_i));
                        sticky_d = req_c_sticky_i;
                        state_d  = ST_DONE;
                    end else begin
                        sum_d    = '0;
                        sticky_d = 1'b0;
                        state_d  = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (w_step_fire) begin
                    sum_d      = sum_q + WA'($signed(acc_sig_i));
                    sticky_d   = sticky_q | acc_sticky_in_i;
                    step_cnt_d = step_cnt_q + SW'(1);
                    if (w_last_step) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (res_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with synchronous abort on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sum_q      <= '0;
            sticky_q   <= 1'b0;
            step_cnt_q <= '0;
            steps_q    <= '0;
            tail_q     <= '0;
            c_sig_q    <= '0;
            c_sticky_q <= 1'b0;
            id_q       <= '0;
        end else begin
            state_q    <= state_d;
            sum_q      <= sum_d;
            sticky_q   <= sticky_d;
            step_cnt_q <= step_cnt_d;
            steps_q    <= steps_d;
            tail_q     <= tail_d;
            c_sig_q    <= c_sig_d;
            c_sticky_q <= c_sticky_d;
            id_q       <= id_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vx_tcu_drl_acc_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vx_tcu_drl_acc_seq
//  Function : Self-checking bench for vx_tcu_drl_acc_seq with a behavioural
//             combinational accumulator model and a directed vector table.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vx_tcu_drl_acc_seq;

    localparam int N  = 5;
    localparam int WI = 26;
    localparam int WO = 30;
    localparam int MS = 8;
    localparam int SW = 4;
    localparam int WA = 33;
    localparam int TW = 3;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 req_valid, req_ready;
    logic [31:0]          req_id;
    logic [SW-1:0]        req_steps;
    logic [TW-1:0]        req_tail;
    logic [WI-1:0]        req_c_sig;
    logic                 req_c_sticky;
    logic                 step_valid, step_ready;
    logic [(N-1)*WI-1:0]  step_sigs;
    logic [N-2:0]         step_sticky;
    logic                 acc_valid;
    logic [31:0]          acc_req_id;
    logic [N-2:0]         acc_lane_mask;
    logic [N*WI-1:0]      acc_sigs;
    logic [N-1:0]         acc_sticky;
    logic [WO-1:0]        acc_sig;
    logic                 acc_sticky_in;
    logic                 res_valid, res_ready;
    logic [31:0]          res_id;
    logic [WA-1:0]        res_sig;
    logic                 res_sticky;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vx_tcu_drl_acc_seq #(.N(N), .WI(WI), .WO(WO), .MAX_STEPS(MS)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_id_i        (req_id),
        .req_steps_i     (req_steps),
        .req_tail_i      (req_tail),
        .req_c_sig_i     (req_c_sig),
        .req_c_sticky_i  (req_c_sticky),
        .step_valid_i    (step_valid),
        .step_ready_o    (step_ready),
        .step_sigs_i     (step_sigs),
        .step_sticky_i   (step_sticky),
        .acc_valid_o     (acc_valid),
        .acc_req_id_o    (acc_req_id),
        .acc_lane_mask_o (acc_lane_mask),
        .acc_sigs_o      (acc_sigs),
        .acc_sticky_o    (acc_sticky),
        .acc_sig_i       (acc_sig),
        .acc_sticky_in_i (acc_sticky_in),
        .res_valid_o     (res_valid),
        .res_ready_i     (res_ready),
        .res_id_o        (res_id),
        .res_sig_o       (res_sig),
        .res_sticky_o    (res_sticky)
    );

    // Behavioural DRL accumulator: masked vector lanes plus the C lane.
    always_comb begin
        acc_sig       = WO'($signed(acc_sigs[(N-1)*WI +: WI]));
        acc_sticky_in = acc_sticky[N-1];
        for (int i = 0; i < N - 1; i++) begin
            if (acc_lane_mask[i]) begin
                acc_sig       = acc_sig + WO'($signed(acc_sigs[i*WI +: WI]));
                acc_sticky_in = acc_sticky_in | acc_sticky[i];
            end
        end
    end

    typedef struct packed {
        logic [SW-1:0]        steps;
        logic [TW-1:0]        tail;
        logic [WI-1:0]        c;
        logic                 cs;
        logic [3:0][WI-1:0]   lanes;
        logic [3:0]           st;
        logic [WA-1:0]        exp_sig;
        logic                 exp_st;
    } vec_t;

    vec_t vecs[9];

    function automatic vec_t mk(int steps, int tail, int c, bit cs,
                                int l0, int l1, int l2, int l3,
                                bit [3:0] st, longint e, bit es);
        vec_t v;
        v.steps    = SW'(steps);
        v.tail     = TW'(tail);
        v.c        = WI'(c);
        v.cs       = cs;
        v.lanes[0] = WI'(l0);
        v.lanes[1] = WI'(l1);
        v.lanes[2] = WI'(l2);
        v.lanes[3] = WI'(l3);
        v.st       = st;
        v.exp_sig  = WA'(e);
        v.exp_st   = es;
        return v;
    endfunction

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Runs one request; gap = idle cycles before each step, hold = cycles of
    // res_ready low once the result is up.
    task automatic run_vec(vec_t v, int gap, int hold, logic [31:0] id);
        int      eff;
        logic [3:0] exp_mask;
        eff = (int'(v.steps) > MS) ? MS : int'(v.steps);
        @(negedge clk);
        chk("req_ready_idle", req_ready, 1);
        req_valid    = 1'b1;
        req_id       = id;
        req_steps    = v.steps;
        req_tail     = v.tail;
        req_c_sig    = v.c;
        req_c_sticky = v.cs;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int s = 0; s < eff; s++) begin
            for (int g = 0; g < gap; g++) begin
                #1;
                chk("acc_valid_gap", acc_valid, 0);
                chk("req_ready_run", req_ready, 0);
                @(negedge clk);
            end
            step_valid  = 1'b1;
            step_sigs   = v.lanes;
            step_sticky = v.st;
            #1;
            exp_mask = 4'hF;
            if (s == eff - 1 && v.tail >= 1 && v.tail <= 3)
                exp_mask = 4'((1 << v.tail) - 1);
            chk("acc_valid", acc_valid, 1);
            chk("acc_lane_mask", acc_lane_mask, exp_mask);
            chk("acc_c_lane", acc_sigs[(N-1)*WI +: WI], (s == 0) ? v.c : 0);
            chk("acc_req_id", acc_req_id, id);
            chk("res_valid_run", res_valid, 0);
            @(posedge clk);
            @(negedge clk);
            step_valid = 1'b0;
        end
        #1;
        chk("acc_valid_done", acc_valid, 0);
        res_ready = 1'b0;
        for (int h = 0; h <= hold; h++) begin
            chk("res_valid", res_valid, 1);
            chk("res_sig", $signed(res_sig), $signed(v.exp_sig));
            chk("res_sticky", res_sticky, v.exp_st);
            chk("res_id", res_id, id);
            chk("req_ready_done", req_ready, 0);
            if (h < hold) @(negedge clk);
            #1;
        end
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        chk("res_valid_after", res_valid, 0);
        chk("req_ready_after", req_ready, 1);
    endtask

    initial begin
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_id       = '0;
        req_steps    = '0;
        req_tail     = '0;
        req_c_sig    = '0;
        req_c_sticky = 1'b0;
        step_valid   = 1'b0;
        step_sigs    = '0;
        step_sticky  = '0;
        res_ready    = 1'b0;

        vecs[0] = mk(1, 0, 5, 0, 1, 2, 3, 4, 4'b0000, 15, 0);
        vecs[1] = mk(3, 2, 0, 0, 1, 1, 1, 1, 4'b0000, 10, 0);
        vecs[2] = mk(8, 0, -1, 0, -1, -1, -1, -1, 4'b0000, -33, 0);
        vecs[3] = mk(12, 0, -1, 0, -1, -1, -1, -1, 4'b0000, -33, 0);
        vecs[4] = mk(0, 0, 7, 1, 9, 9, 9, 9, 4'b1111, 7, 1);
        vecs[5] = mk(2, 1, 10, 0, 100, -50, 3, 7, 4'b1000, 170, 1);
        vecs[6] = mk(1, 1, 0, 0, 5, 6, 7, 8, 4'b0010, 5, 0);
        vecs[7] = mk(3, 4, 2, 0, 1, 2, 3, 4, 4'b0000, 32, 0);
        vecs[8] = mk(4, 3, -3, 0, 1000, 2000, -4000, 5, 4'b0000, -3988, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_step_ready", step_ready, 0);
        chk("rst_acc_valid", acc_valid, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_sig", res_sig, 0);
        chk("rst_res_sticky", res_sticky, 0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], 0, 0, 32'hA000_0000 + 32'(i));
        end

        // Stalled steps and back-pressured result.
        run_vec(vecs[8], 2, 3, 32'hBEEF_0005);

        // Abort mid-request with reset after 2 of 4 steps.
        @(negedge clk);
        req_valid    = 1'b1;
        req_id       = 32'h0000_0066;
        req_steps    = 4'd4;
        req_tail     = '0;
        req_c_sig    = WI'(1);
        req_c_sticky = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid   = 1'b0;
        step_valid  = 1'b1;
        step_sigs   = {4{WI'(3)}};
        step_sticky = 4'b1111;
        repeat (2) @(posedge clk);
        @(negedge clk);
        step_valid = 1'b0;
        reset      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_req_ready", req_ready, 1);
        chk("abort_res_valid", res_valid, 0);
        chk("abort_step_ready", step_ready, 0);
        chk("abort_acc_valid", acc_valid, 0);
        run_vec(vecs[0], 0, 0, 32'h0000_0077);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop in case the sequence never completes.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
